fir_mac_engine: RTL and testbench
=================================

Name: fir_mac_engine

Overview:
Serial 64-tap FIR multiply-accumulate stage directly downstream of the coefficient shadow bank. It drives current_count to select one coefficient per cycle and consumes the returned product_mux coefficient. It holds the sample delay line as a circular buffer and produces one rounded, saturated 16-bit output per accepted input sample. Each equalizer band instantiates one engine.

Parameters:
NUM_TAPS, 64, number of taps; must equal the coefficient bank depth.
DATA_W, 16, signed sample width.
COEFF_W, 16, signed coefficient width (Q1.15).
ACC_W, 40, signed accumulator width; must be at least DATA_W+COEFF_W+log2(NUM_TAPS).
OUT_SHIFT, 15, arithmetic right shift applied to the accumulator before output.

Ports:
clk  in  1  Single clock for the whole block.
rst  in  1  Asynchronous, active-low reset (asserted when 0).
clk_enable  in  1  Global advance enable; when 0, all state holds.
sample_in  in  16  Signed input sample.
sample_valid  in  1  sample_in is valid.
sample_ready  out  1  Engine is able to accept a sample.
current_count  out  6  Tap index that drives coefficient selection.
product_mux  in  16  Signed coefficient for current_count; combinational, same cycle.
filter_out  out  16  Signed filtered sample.
out_valid  out  1  One-cycle pulse marking a new filter_out value.
busy  out  1  Engine is in MAC or ROUND; the upstream stage must not issue coeffs_en while busy is high.

Behaviour:
- Reset (rst=0, asynchronous) takes effect immediately:
  - state returns to IDLE; wr_ptr=0; acc=0; all 64 delay entries=0.
  - current_count=0, filter_out=0, out_valid=0, busy=0, sample_ready=1.
- All register updates occur only on clk edges with clk_enable=1. With clk_enable=0, everything holds and out_valid stays at its current value.
- sample_ready = (state==IDLE). A sample is accepted when sample_valid & sample_ready & clk_enable are all high.
- State IDLE, on accept:
  - delay[wr_ptr] <= sample_in; acc <= 0; current_count <= 0.
  - next state MAC.
- State MAC, each enabled edge:
  - acc <= acc + delay[(wr_ptr - current_count) mod 64] * product_mux (full 32-bit signed product, sign-extended to ACC_W).
  - current_count increments. At current_count==63 it wraps to 0 and state moves to ROUND.
- State ROUND, one enabled edge:
  - filter_out <= sat16((acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT), i.e. round half up, then clip to [-32768, 32767].
  - out_valid <= 1; wr_ptr <= wr_ptr+1 (wraps mod 64); next state IDLE.
- out_valid clears on the next enabled edge. filter_out holds its value until the next ROUND.
- Latency: out_valid asserts 65 enabled edges after the accept edge. Throughput: one sample per 66 enabled cycles.
- A sample_valid held while busy is not accepted; no input is dropped or duplicated.
- Newest sample pairs with tap 0. Index arithmetic uses 6-bit natural wrap.
- state encoding: IDLE=2'd0, MAC=2'd1, ROUND=2'd2. The unused code 2'd3 returns to IDLE.

Optional Feature:
Macro FIR_SAT_STATUS_EN.
- Defined:
  - Adds input sat_clr (1 bit) and output sat_flag (1 bit).
  - sat_flag is sticky: set in ROUND when clipping occurs; cleared by reset or by sat_clr=1 on an enabled edge.
  - A set and a clear on the same edge resolve as set.
- Undefined: neither port exists and no saturation-detect logic is built.

Decomposition:
- Package fir_pkg holds NUM_TAPS, DATA_W, COEFF_W, ACC_W, OUT_SHIFT, the state encoding localparams, and the Q15 min/max constants.
- One sub-module, fir_round_sat: combinational round, shift and saturate from ACC_W to 16 bits. It also provides the clip indicator used by FIR_SAT_STATUS_EN.

Test Plan:
1. Single tap: coeff[0]=0x4000, all others 0; feed 0x1000 -> filter_out=0x0800, out_valid high exactly 65 enabled edges after the accept edge.
2. Impulse response: coeff[k]=k*256; feed 0x4000 followed by 63 zeros -> n-th output = 128*n for n=0..63; the 65th output = 0.
3. Saturation: all coeffs 0x7FFF, 64 samples of 0x7FFF -> final output 0x7FFF; with samples of 0x8000 -> 0x8000. With FIR_SAT_STATUS_EN, sat_flag=1 until sat_clr is pulsed.
4. Stall: random 50% clk_enable during MAC -> bit-identical outputs to the unstalled run; current_count holds whenever clk_enable is low.
5. Backpressure: sample_valid held high continuously -> exactly one accept per 66 enabled cycles, sample_ready low for 65 of them, busy the complement of sample_ready.
6. Reset mid-MAC at current_count=30 -> all outputs return to reset values immediately. The next impulse then reproduces scenario 2 exactly, showing the history was cleared.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared sizing, FSM encoding and Q15 limits for the serial FIR MAC engine.
package fir_pkg;
    localparam int NUM_TAPS  = 64;
    localparam int DATA_W    = 16;
    localparam int COEFF_W   = 16;
    localparam int ACC_W     = 40;
    localparam int OUT_SHIFT = 15;
    localparam int CNT_W     = $clog2(NUM_TAPS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MAC   = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        MAC   = ST_MAC,
        ROUND = ST_ROUND
    } state_t;

    localparam logic signed [DATA_W-1:0] Q15_MAX = 16'sh7FFF;
    localparam logic signed [DATA_W-1:0] Q15_MIN = 16'sh8000;
endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up, arithmetic shift and clip of the accumulator to a Q15 sample.
// With FIR_SAT_STATUS_EN the clip indicator is exported.
module fir_round_sat
    import fir_pkg::*;
(
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] y
`ifdef FIR_SAT_STATUS_EN
    ,
    output logic                     clip
`endif
);
    // One guard bit so the rounding bias cannot wrap a near-full accumulator.
    localparam logic signed [ACC_W:0] HALF =
        {{(ACC_W-OUT_SHIFT+1){1'b0}}, 1'b1, {(OUT_SHIFT-1){1'b0}}};
    localparam logic signed [ACC_W:0] MAX_EXT = {{(ACC_W+1-DATA_W){1'b0}}, Q15_MAX};
    localparam logic signed [ACC_W:0] MIN_EXT = {{(ACC_W+1-DATA_W){1'b1}}, Q15_MIN};

    logic signed [ACC_W:0] biased;
    logic signed [ACC_W:0] shifted;
    logic                  hi;
    logic                  lo;

    assign biased  = {acc[ACC_W-1], acc} + HALF;
    assign shifted = biased >>> OUT_SHIFT;
    assign hi      = shifted > MAX_EXT;
    assign lo      = shifted < MIN_EXT;
    assign y       = hi ? Q15_MAX : (lo ? Q15_MIN : shifted[DATA_W-1:0]);

`ifdef FIR_SAT_STATUS_EN
    assign clip = hi | lo;
`endif
endmodule

// File: rtl/fir_mac_engine.sv
// Serial 64-tap FIR MAC: circular delay line, one tap per cycle, rounded/saturated output.
// Optional sticky saturation status under FIR_SAT_STATUS_EN (adds sat_clr / sat_flag).
module fir_mac_engine
    import fir_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_enable,
    input  logic signed [DATA_W-1:0]  sample_in,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    output logic [CNT_W-1:0]          current_count,
    input  logic signed [COEFF_W-1:0] product_mux,
    output logic signed [DATA_W-1:0]  filter_out,
    output logic                      out_valid,
    output logic                      busy
`ifdef FIR_SAT_STATUS_EN
    ,
    input  logic                      sat_clr,
    output logic                      sat_flag
`endif
);
    state_t                           state;
    logic [CNT_W-1:0]                 wr_ptr;
    logic signed [ACC_W-1:0]          acc;
    logic signed [DATA_W-1:0]         delay [NUM_TAPS];
    logic [CNT_W-1:0]                 rd_idx;
    logic signed [DATA_W+COEFF_W-1:0] prod;
    logic signed [DATA_W-1:0]         rounded;

    // Newest sample sits at wr_ptr and pairs with tap 0.
    assign rd_idx       = wr_ptr - current_count;
    assign prod         = delay[rd_idx] * product_mux;
    assign sample_ready = (state == IDLE);
    assign busy         = (state == MAC) || (state == ROUND);

`ifdef FIR_SAT_STATUS_EN
    logic clip;

    fir_round_sat u_round_sat (
        .acc  (acc),
        .y    (rounded),
        .clip (clip)
    );

    // Set wins over a same-edge clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sat_flag <= 1'b0;
        else if (clk_enable) begin
            if (state == ROUND && clip)
                sat_flag <= 1'b1;
            else if (sat_clr)
                sat_flag <= 1'b0;
        end
    end
`else
    fir_round_sat u_round_sat (
        .acc (acc),
        .y   (rounded)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            acc           <= '0;
            current_count <= '0;
            filter_out    <= '0;
            out_valid     <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++)
                delay[i] <= '0;
        end else if (clk_enable) begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        delay[wr_ptr] <= sample_in;
                        acc           <= '0;
                        current_count <= '0;
                        state         <= MAC;
                    end
                end
                MAC: begin
                    acc           <= acc + ACC_W'(prod);
                    current_count <= current_count + 1'b1;
                    if (current_count == CNT_W'(NUM_TAPS-1))
                        state <= ROUND;
                end
                ROUND: begin
                    filter_out <= rounded;
                    out_valid  <= 1'b1;
                    wr_ptr     <= wr_ptr + 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_mac_engine.sv
// Directed bench for fir_mac_engine: single tap, impulse, saturation, stall, backpressure, reset.
module tb_fir_mac_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk_enable = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_in = 16'h0;
    logic [15:0] product_mux;
    logic [15:0] filter_out;
    logic [5:0]  current_count;
    logic        sample_ready;
    logic        out_valid;
    logic        busy;
`ifdef FIR_SAT_STATUS_EN
    logic        sat_clr = 1'b0;
    logic        sat_flag;
`endif

    logic [15:0] coeff [64];
    int          n_chk = 0;
    int          n_fail = 0;
    int          hold_err = 0;
    bit          stall = 1'b0;

    assign product_mux = coeff[current_count];
    always #5 clk = ~clk;

    fir_mac_engine dut (
        .clk           (clk),
        .rst           (rst),
        .clk_enable    (clk_enable),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .current_count (current_count),
        .product_mux   (product_mux),
        .filter_out    (filter_out),
        .out_valid     (out_valid),
        .busy          (busy)
`ifdef FIR_SAT_STATUS_EN
        ,
        .sat_clr       (sat_clr),
        .sat_flag      (sat_flag)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_en();
        clk_enable = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic push(input logic [15:0] s, output logic [15:0] y, output int lat);
        bit         accepted;
        logic [5:0] prev;
        int         budget;
        y = '0; lat = 0; accepted = 1'b0; budget = 0;
        sample_in = s;
        sample_valid = 1'b1;
        while (!accepted && budget < 1000) begin
            drive_en();
            accepted = sample_ready && clk_enable;
            tick();
            budget++;
        end
        sample_valid = 1'b0;
        if (!accepted) begin
            chk("accept_timeout", 0, 1);
            return;
        end
        budget = 0;
        do begin
            drive_en();
            prev = current_count;
            tick();
            if (clk_enable) lat++;
            else if (current_count !== prev) hold_err++;
            budget++;
        end while (!out_valid && budget < 1000);
        if (!out_valid) chk("out_timeout", 0, 1);
        y = filter_out;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clk_enable = 1'b0;
        sample_valid = 1'b0;
        stall = 1'b0;
        #2;
        @(negedge clk);
        rst = 1'b1;
        clk_enable = 1'b1;
    endtask

    // coeff[k] = k*256 with a 0x4000 impulse gives 128*n at output n.
    task automatic impulse_run(input string tag);
        logic [15:0] y;
        int          lat;
        for (int k = 0; k < 64; k++) coeff[k] = 16'(k * 256);
        for (int n = 0; n < 65; n++) begin
            push((n == 0) ? 16'h4000 : 16'h0000, y, lat);
            chk($sformatf("%s_out[%0d]", tag, n), y, (n < 64) ? 32'(128 * n) : 32'h0);
            if (n == 0) chk($sformatf("%s_lat", tag), lat, 65);
        end
    endtask

    initial begin
        logic [15:0] y;
        int          lat;
        int          acc_cyc[$];
        int          low;
        int          bad;
        int          budget;

        for (int k = 0; k < 64; k++) coeff[k] = 16'h0;
        #12;
        chk("rst_count", current_count, 0);
        chk("rst_out", filter_out, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", sample_ready, 1);
        @(negedge clk);
        rst = 1'b1;

        // Single tap
        coeff[0] = 16'h4000;
        push(16'h1000, y, lat);
        chk("t1_out", y, 16'h0800);
        chk("t1_lat", lat, 65);
        clk_enable = 1'b0;
        tick();
        chk("t1_valid_hold", out_valid, 1);
        clk_enable = 1'b1;
        tick();
        chk("t1_valid_clear", out_valid, 0);
        chk("t1_out_hold", filter_out, 16'h0800);

        // Impulse response from clean history
        do_reset();
        impulse_run("t2");

        // Saturation, both polarities
        for (int k = 0; k < 64; k++) coeff[k] = 16'h7FFF;
        for (int n = 0; n < 64; n++) begin
            push(16'h7FFF, y, lat);
            if (n == 0) begin
                chk("t3_first_unsat", y, 16'h7FFE);
`ifdef FIR_SAT_STATUS_EN
                chk("t3_flag_clear0", sat_flag, 0);
`endif
            end
            if (n == 1) chk("t3_second_sat", y, 16'h7FFF);
        end
        chk("t3_pos", y, 16'h7FFF);
`ifdef FIR_SAT_STATUS_EN
        chk("t3_flag_set", sat_flag, 1);
        clk_enable = 1'b0;
        sat_clr = 1'b1;
        tick();
        chk("t3_flag_hold_noen", sat_flag, 1);
        clk_enable = 1'b1;
        tick();
        sat_clr = 1'b0;
        chk("t3_flag_cleared", sat_flag, 0);
`endif
        for (int n = 0; n < 64; n++) push(16'h8000, y, lat);
        chk("t3_neg", y, 16'h8000);
`ifdef FIR_SAT_STATUS_EN
        chk("t3_flag_set_neg", sat_flag, 1);
`endif

        // Random clock-enable stalls
        do_reset();
        stall = 1'b1;
        hold_err = 0;
        impulse_run("t4");
        stall = 1'b0;
        clk_enable = 1'b1;
        chk("t4_count_hold", hold_err, 0);

        // Backpressure with sample_valid held high
        low = 0; bad = 0;
        sample_in = 16'h1000;
        sample_valid = 1'b1;
        for (int c = 0; c < 198; c++) begin
            if (busy === sample_ready) bad++;
            if (sample_ready) acc_cyc.push_back(c);
            else if (acc_cyc.size() == 1) low++;
            tick();
        end
        sample_valid = 1'b0;
        chk("t5_accepts", acc_cyc.size(), 3);
        if (acc_cyc.size() == 3) begin
            chk("t5_gap1", acc_cyc[1] - acc_cyc[0], 66);
            chk("t5_gap2", acc_cyc[2] - acc_cyc[1], 66);
        end
        chk("t5_ready_low", low, 65);
        chk("t5_busy_compl", bad, 0);

        // Reset in the middle of a MAC pass
        sample_in = 16'h4000;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        budget = 0;
        while (current_count != 6'd30 && budget < 100) begin
            tick();
            budget++;
        end
        chk("t6_mid_count", current_count, 30);
        chk("t6_mid_busy", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_count", current_count, 0);
        chk("t6_rst_out", filter_out, 0);
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ready", sample_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        impulse_run("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
